// File: rtl/pipe_addsub_alu_pkg.sv
// Shared definitions for the pipelined add/sub/logic ALU.
// Optional feature macro: ALU_CC_REG_EN (adds a set_cc bit to the beat control).
// The width-dependent part of a beat (partial result, operands) is sized
// by W. Because this package has no W parameter, that part is declared in
// the top module around beat_ctl_t.
package alu_pkg;

  typedef enum logic [1:0] {
    FN_ADD = 2'd0,  // b + a
    FN_SUB = 2'd1,  // b - a, computed as b + ~a + 1
    FN_AND = 2'd2,
    FN_XOR = 2'd3
  } alu_fn_e;

  // Width-independent part of a beat travelling down the pipe.
  typedef struct packed {
    alu_fn_e fn;
    logic    carry;   // carry into the next slice
`ifdef ALU_CC_REG_EN
    logic    set_cc;  // beat updates the CC register when it leaves
`endif
  } beat_ctl_t;

  function automatic logic is_arith(alu_fn_e fn);
    return (fn == FN_ADD) || (fn == FN_SUB);
  endfunction

endpackage

// File: rtl/pipe_addsub_alu_if.sv
// Operand/result handshake bundle for pipe_addsub_alu.
// Optional feature macro: ALU_CC_REG_EN (adds set_cc and the cc_* outputs).
interface pipe_addsub_alu_if #(parameter int W = 64);
  import alu_pkg::*;

  logic          in_valid;
  logic          in_ready;
  alu_fn_e       fn;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cf;
  logic          zf;
  logic          sf;
  logic          of;
`ifdef ALU_CC_REG_EN
  logic          set_cc;
  logic          cc_zf;
  logic          cc_sf;
  logic          cc_of;
`endif

  // ALU side
  modport slave (
    input  in_valid, fn, a, b, out_ready,
`ifdef ALU_CC_REG_EN
    input  set_cc,
    output cc_zf, cc_sf, cc_of,
`endif
    output in_ready, out_valid, result, cf, zf, sf, of
  );

  // Producer/consumer side
  modport master (
    output in_valid, fn, a, b, out_ready,
`ifdef ALU_CC_REG_EN
    output set_cc,
    input  cc_zf, cc_sf, cc_of,
`endif
    input  in_ready, out_valid, result, cf, zf, sf, of
  );

endinterface

// File: rtl/pipe_addsub_alu_slice.sv
// One SW-bit carry-chain slice: add/sub/and/xor with carry in and out.
// For SUB, the caller supplies carry-in 1 to the first slice, which
// completes the two's complement of a.
module addsub_slice
  import alu_pkg::*;
#(
  parameter int SW = 16
) (
  input  alu_fn_e       fn_i,
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          ci_i,
  output logic [SW-1:0] s_o,
  output logic          co_o
);

  logic [SW:0] sum;

  // Slice sum plus the logic ops; logic ops never produce a carry.
  always_comb begin
    sum  = {1'b0, b_i} + {1'b0, (fn_i == FN_SUB) ? ~a_i : a_i} + {{SW{1'b0}}, ci_i};
    s_o  = sum[SW-1:0];
    co_o = 1'b0;
    case (fn_i)
      FN_ADD, FN_SUB: begin
        s_o  = sum[SW-1:0];
        co_o = sum[SW];
      end
      FN_AND: s_o = a_i & b_i;
      FN_XOR: s_o = a_i ^ b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_addsub_alu.sv
// Pipelined W-bit add/sub/and/xor with STAGES carry-chain slices.
// Each beat moves one slice per clock. Flags are registered alongside the
// final slice. A single global advance stalls the whole pipe on output
// back-pressure.
// Optional feature macro: ALU_CC_REG_EN (zf/sf/of condition-code register
// loaded on output handshake of beats tagged set_cc).
module pipe_addsub_alu
  import alu_pkg::*;
#(
  parameter int W      = 64,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_addsub_alu_if.slave  bus
);

  localparam int SW = W / STAGES;

  if (STAGES < 1 || STAGES > W || (W % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_addsub_alu: STAGES must be in 1..W and divide W");
  end

  typedef struct packed {
    beat_ctl_t    ctl;
    logic [W-1:0] res;  // completed low slices
    logic [W-1:0] a;    // operands kept whole: high slices pending, top bits for of
    logic [W-1:0] b;
  } beat_t;

  logic              adv;
  logic              in_fire;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;
  beat_t             in_beat;
  beat_t             tail_d;
  beat_t             tail_q;

  assign adv          = !vld_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;
  assign in_fire      = bus.in_valid && adv;
  assign vld_pipe     = {vld_q, in_fire};

  // Valid shift register; bubbles move with the pipe, they are not squeezed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Package the incoming operands as a fresh beat; SUB seeds the chain with 1.
  always_comb begin
    in_beat           = '0;
    in_beat.ctl.fn    = bus.fn;
    in_beat.ctl.carry = (bus.fn == FN_SUB);
`ifdef ALU_CC_REG_EN
    in_beat.ctl.set_cc = bus.set_cc;
`endif
    in_beat.a         = bus.a;
    in_beat.b         = bus.b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    beat_t         src;
    beat_t         stg_d;
    beat_t         stg_q;
    logic [SW-1:0] s;
    logic          co;

    if (k == 0) begin : g_src_in
      assign src = in_beat;
    end else begin : g_src_prev
      assign src = g_st[k-1].stg_q;
    end

    addsub_slice #(.SW(SW)) u_slice (
      .fn_i (src.ctl.fn),
      .a_i  (src.a[k*SW +: SW]),
      .b_i  (src.b[k*SW +: SW]),
      .ci_i (src.ctl.carry),
      .s_o  (s),
      .co_o (co)
    );

    // Drop this slice's sum into the beat and forward its carry.
    always_comb begin
      stg_d                  = src;
      stg_d.res[k*SW +: SW]  = s;
      stg_d.ctl.carry        = co;
    end

    // Stage register; bubbles do not overwrite, so a stage keeps its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  stg_q <= '0;
      else if (adv && vld_pipe[k]) stg_q <= stg_d;
    end
  end

  assign tail_d = g_st[STAGES-1].stg_d;
  assign tail_q = g_st[STAGES-1].stg_q;

  logic cf_d, zf_d, sf_d, of_d;
  logic cf_q, zf_q, sf_q, of_q;

  // Flags from the completed result of the beat entering the output register.
  always_comb begin
    cf_d = is_arith(tail_d.ctl.fn) && tail_d.ctl.carry;
    zf_d = (tail_d.res == '0);
    sf_d = tail_d.res[W-1];
    of_d = 1'b0;
    case (tail_d.ctl.fn)
      FN_ADD: of_d = (tail_d.a[W-1] == tail_d.b[W-1]) && (tail_d.res[W-1] != tail_d.b[W-1]);
      FN_SUB: of_d = (tail_d.a[W-1] != tail_d.b[W-1]) && (tail_d.res[W-1] != tail_d.b[W-1]);
      default: ;
    endcase
  end

  // Flags register, loaded in step with the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cf_q, zf_q, sf_q, of_q} <= '0;
    end else if (adv && vld_pipe[STAGES-1]) begin
      {cf_q, zf_q, sf_q, of_q} <= {cf_d, zf_d, sf_d, of_d};
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.result    = tail_q.res;
  assign bus.cf        = cf_q;
  assign bus.zf        = zf_q;
  assign bus.sf        = sf_q;
  assign bus.of        = of_q;

`ifdef ALU_CC_REG_EN
  logic cc_zf_q, cc_sf_q, cc_of_q;

  // CC register follows only tagged beats as they leave the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cc_zf_q, cc_sf_q, cc_of_q} <= '0;
    end else if (bus.out_valid && bus.out_ready && tail_q.ctl.set_cc) begin
      {cc_zf_q, cc_sf_q, cc_of_q} <= {zf_q, sf_q, of_q};
    end
  end

  assign bus.cc_zf = cc_zf_q;
  assign bus.cc_sf = cc_sf_q;
  assign bus.cc_of = cc_of_q;
`endif

  // Operands and control are dead once the last slice is done.
  logic unused_tail;
  assign unused_tail = ^{tail_q.ctl, tail_q.a, tail_q.b};

endmodule

// File: tb/tb_pipe_addsub_alu.sv
// Bench for pipe_addsub_alu: arithmetic reference model + scoreboard,
// directed vectors, back-pressure stream and mid-flight reset.
// Optional feature macro: ALU_CC_REG_EN (CC register is modelled when defined).
module tb_pipe_addsub_alu;
  import alu_pkg::*;

  localparam int W      = 64;
  localparam int STAGES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_addsub_alu_if #(.W(W)) bus ();

  pipe_addsub_alu #(.W(W), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;   // {cf, zf, sf, of}
    logic         sc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rmode  = 0;     // 0: always ready, 1: 1,0,0,1 pattern, 2: never ready
  int   out_cnt = 0;
  exp_t q[$];
  int   out_cycs[$];
  logic [2:0] cc_m = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic straight from the flag definitions.
  function automatic exp_t model(input alu_fn_e fn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic sc);
    exp_t       e;
    logic [W:0] wide;
    logic       cf;
    logic       of;
    cf = 1'b0;
    of = 1'b0;
    e.sc = sc;
    e.res = '0;
    case (fn)
      FN_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        e.res = wide[W-1:0];
        cf    = wide[W];
        of    = (a[W-1] == b[W-1]) && (e.res[W-1] != b[W-1]);
      end
      FN_SUB: begin
        e.res = b - a;
        cf    = (b >= a);
        of    = (a[W-1] != b[W-1]) && (e.res[W-1] != b[W-1]);
      end
      FN_AND: e.res = a & b;
      FN_XOR: e.res = a ^ b;
      default: ;
    endcase
    e.fl = {cf, (e.res == '0), e.res[W-1], of};
    return e;
  endfunction

  function automatic logic [3:0] dut_fl();
    return {bus.cf, bus.zf, bus.sf, bus.of};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready driver.
  initial begin
    int pi;
    pi = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = (pi % 4 == 0) || (pi % 4 == 3);
          pi++;
        end
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: inputs are stable from posedge+1, so the negedge sees what
  // the next rising edge will act on.
  initial begin
    logic         prev_stall;
    logic [W+3:0] prev_val;
    exp_t         e;
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        prev_stall = 1'b0;
        cc_m       = '0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {bus.out_valid, bus.result, dut_fl()}, {1'b1, prev_val});
`ifdef ALU_CC_REG_EN
        chk("cc_reg", {bus.cc_zf, bus.cc_sf, bus.cc_of}, cc_m);
`endif
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", bus.out_valid, 0);
          end else begin
            e = q.pop_front();
            chk("result_flags", {bus.result, dut_fl()}, {e.res, e.fl});
            out_cnt++;
            out_cycs.push_back(cyc);
            if (e.sc) cc_m = e.fl[2:0];
          end
        end
        if (bus.in_valid && bus.in_ready) begin
`ifdef ALU_CC_REG_EN
          q.push_back(model(bus.fn, bus.a, bus.b, bus.set_cc));
`else
          q.push_back(model(bus.fn, bus.a, bus.b, 1'b0));
`endif
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_val   = {bus.result, dut_fl()};
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input alu_fn_e fn, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic sc);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.fn = fn;
    bus.a  = a;
    bus.b  = b;
`ifdef ALU_CC_REG_EN
    bus.set_cc = sc;
`endif
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int   n;
    int   base;

    // Reset held with a valid beat presented.
    bus.in_valid = 1'b1;
    bus.fn = FN_ADD;
    bus.a  = 64'd5;
    bus.b  = 64'd7;
`ifdef ALU_CC_REG_EN
    bus.set_cc = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_flags", dut_fl(), 0);
`ifdef ALU_CC_REG_EN
    chk("reset_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 0);
`endif

    // First beat accepted on the first edge after release; measure latency.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_latency", n, STAGES);
    drain("drain_first");

    // Pin the model to hand-computed values.
    m = model(FN_SUB, 64'd31, 64'd63, 1'b0);
    chk("pin_sub_pos", {m.res, m.fl}, {64'd32, 4'b1000});
    m = model(FN_SUB, 64'd63, 64'd31, 1'b0);
    chk("pin_sub_neg", {m.res, m.fl}, {64'hFFFF_FFFF_FFFF_FFE0, 4'b0010});
    m = model(FN_ADD, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0);
    chk("pin_add_carry", {m.res, m.fl}, {64'h0000_0001_0000_0000, 4'b0000});
    m = model(FN_ADD, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    chk("pin_add_ovf", {m.res, m.fl}, {64'h8000_0000_0000_0000, 4'b0011});
    m = model(FN_SUB, 64'h1234, 64'h1234, 1'b0);
    chk("pin_sub_zero", {m.res, m.fl}, {64'd0, 4'b1100});
    m = model(FN_XOR, 64'hABCD, 64'hABCD, 1'b0);
    chk("pin_xor_zero", {m.res, m.fl}, {64'd0, 4'b0100});
    m = model(FN_AND, 64'h0FF0, 64'hF0F0, 1'b0);
    chk("pin_and", {m.res, m.fl}, {64'h00F0, 4'b0000});

    // Directed vectors through the DUT, back to back.
    send(FN_SUB, 64'd31, 64'd63, 1'b1);
    send(FN_SUB, 64'd63, 64'd31, 1'b0);
    send(FN_ADD, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b1);
    send(FN_ADD, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    send(FN_SUB, 64'h1234, 64'h1234, 1'b0);
    send(FN_XOR, 64'hABCD, 64'hABCD, 1'b1);
    send(FN_AND, 64'h0FF0, 64'hF0F0, 1'b0);
    send(FN_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    send(FN_SUB, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
    drain("drain_directed");

    // Full-throughput stream: outputs on consecutive cycles.
    out_cycs.delete();
    base = out_cnt;
    for (int i = 0; i < 8; i++)
      send(alu_fn_e'(i % 4), 64'h0123_4567_89AB_CDEF * (i + 1), 64'hFEDC_BA98_7654_3210 + i, i[0]);
    drain("drain_stream");
    chk("stream_count", out_cnt - base, 8);
    if (out_cycs.size() == 8) chk("stream_no_gaps", out_cycs[7] - out_cycs[0], 7);

    // Back-pressure stream with out_ready 1,0,0,1.
    rmode = 1;
    base = out_cnt;
    for (int i = 0; i < 16; i++)
      send(alu_fn_e'((i * 3) % 4), 64'hFFFF_0000_FFFF_0000 ^ (64'd1 << (i * 4)),
           64'h0000_FFFF_0000_FFFF + (64'h1_0000_0001 * i), i[1]);
    drain("drain_bp");
    chk("bp_count", out_cnt - base, 16);

    // Mid-flight reset with 3 beats in the pipe and output stalled.
    rmode = 2;
    @(posedge clk);
    #1;
    send(FN_ADD, 64'd10, 64'd20, 1'b1);
    send(FN_SUB, 64'd5, 64'd3, 1'b1);
    send(FN_XOR, 64'hFF, 64'h0F, 1'b1);
    repeat (STAGES) @(posedge clk);
    #1;
    chk("inflight_valid", bus.out_valid, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_valid", bus.out_valid, 0);
    chk("reset_clears_result", {bus.result, dut_fl()}, 0);
`ifdef ALU_CC_REG_EN
    chk("reset_clears_cc", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 0);
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    rmode = 0;
    for (int i = 0; i < STAGES + 4; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", bus.out_valid, 0);
    end

    // Recovery after reset.
    @(posedge clk);
    #1;
    send(FN_ADD, 64'd2, 64'd40, 1'b1);
    drain("drain_recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
